systolic_row_packer: RTL and testbench

Downstream drain stage for `systolic_array`. It consumes the array's serial result stream on a valid/yumi handshake and drives the array's `yumi_i` itself. It packs every `array_width_p` consecutive results into one row word and buffers completed rows in a 2-entry FIFO. Rows are presented to the result sink on a valid/ready handshake, tagged with their row index and a last-row-of-frame flag.

---
 rtl/systolic_row_packer.sv | 186 ++++++++++++++++++
 tb/tb_systolic_row_packer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_row_packer.sv
// systolic_row_packer
//   Drain stage for systolic_array. Takes the array's serial result stream on a
//   valid/yumi handshake, packs array_width_p consecutive elements into one row
//   word, queues completed rows in a 2-entry FIFO and offers them to the sink on
//   a valid/ready handshake. Each row carries its index within the frame and a
//   last-row flag.
//
//   Optional feature macro: SYSTOLIC_ROW_PACKER_CHECKSUM_EN
//     When defined, adds a 16-bit per-frame checksum of all accepted elements,
//     exposed on checksum_o.
//
//   Ports
//     clk_i        clock, all state on posedge
//     reset_i      asynchronous active-high reset
//     flush_i      synchronous discard of partial row, FIFO and counters
//     valid_i      array result valid
//     data_i       array result element
//     yumi_o       element consumed this cycle (to array yumi_i)
//     valid_o      packed row available at FIFO head
//     ready_i      sink accepts head row
//     data_o       packed row, first-received element in the low bits
//     row_o        row index of head row within frame
//     last_o       head row is the final row of the frame
//     frame_done_o one-cycle pulse after the last row of a frame is popped
//     busy_o       partial row held or FIFO non-empty
//     checksum_o   frame checksum (macro only)
module systolic_row_packer #(
  parameter int width_p        = 8,
  parameter int array_width_p  = 8,
  parameter int array_height_p = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               valid_i,
  input  logic [width_p-1:0]                 data_i,
  output logic                               yumi_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [width_p*array_width_p-1:0]   data_o,
  output logic [$clog2(array_height_p)-1:0]  row_o,
  output logic                               last_o,
  output logic                               frame_done_o,
  output logic                               busy_o
`ifdef SYSTOLIC_ROW_PACKER_CHECKSUM_EN
  ,
  output logic [15:0]                        checksum_o
`endif
);

  localparam int CW     = (array_width_p > 1) ? $clog2(array_width_p) : 1;
  localparam int RW     = $clog2(array_height_p);
  localparam int ROW_W  = width_p * array_width_p;
  localparam logic [CW-1:0] COL_LAST = CW'(array_width_p - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(array_height_p - 1);

  // Column / row counters and FIFO bookkeeping (control state, reset)
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    count;
  logic          wr_ptr;
  logic          rd_ptr;
  logic          frame_done_q;

  // Assembly slots and FIFO storage (data, not reset; masked at the outputs)
  logic [width_p-1:0] slot [array_width_p];
  logic [ROW_W-1:0]   mem_data [2];
  logic [RW-1:0]      mem_row  [2];
  logic               mem_last [2];

  logic             col_last;
  logic             row_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [ROW_W-1:0] row_word;

  assign col_last   = (col == COL_LAST);
  assign row_last   = (row == ROW_LAST);
  assign fifo_full  = (count == 2'd2);
  assign fifo_empty = (count == 2'd0);

  // Only the row-completing element can be held off, and only by a full FIFO.
  // ready_i deliberately does not feed yumi_o.
  assign yumi_o = valid_i & ~flush_i & ~(col_last & fifo_full);
  assign push   = yumi_o & col_last;
  assign pop    = valid_o & ready_i & ~flush_i;

  assign valid_o      = ~fifo_empty;
  assign busy_o       = (col != '0) | ~fifo_empty;
  assign frame_done_o = frame_done_q;

  // Empty FIFO presents zeros so the unreset storage never leaks to the sink.
  assign data_o = fifo_empty ? '0 : mem_data[rd_ptr];
  assign row_o  = fifo_empty ? '0 : mem_row[rd_ptr];
  assign last_o = fifo_empty ? 1'b0 : mem_last[rd_ptr];

  // The incoming element completes the row directly, without a slot write.
  always_comb begin
    row_word = '0;
    for (int i = 0; i < array_width_p - 1; i++) begin
      row_word[i*width_p +: width_p] = slot[i];
    end
    row_word[(array_width_p-1)*width_p +: width_p] = data_i;
  end

  // ---- control stage ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col          <= '0;
      row          <= '0;
      count        <= 2'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (flush_i) begin
      col          <= '0;
      row          <= '0;
      count        <= 2'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (yumi_o) begin
        col <= col_last ? '0 : col + CW'(1);
      end
      if (push) begin
        row    <= row_last ? '0 : row + RW'(1);
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      frame_done_q <= pop & last_o;
    end
  end

  // ---- data stage ----
  always_ff @(posedge clk_i) begin
    if (yumi_o && !col_last) begin
      slot[col] <= data_i;
    end
    if (push) begin
      mem_data[wr_ptr] <= row_word;
      mem_row[wr_ptr]  <= row;
      mem_last[wr_ptr] <= row_last;
    end
  end

`ifdef SYSTOLIC_ROW_PACKER_CHECKSUM_EN
  logic [15:0] acc;
  logic [15:0] checksum_q;

  // Zero-extend the element and wrap modulo 2^16.
  function automatic logic [15:0] csum_add(input logic [15:0] a,
                                           input logic [width_p-1:0] d);
    return a + 16'(d);
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc        <= '0;
      checksum_q <= '0;
    end else if (flush_i) begin
      acc        <= '0;
      checksum_q <= '0;
    end else if (yumi_o) begin
      if (push && row_last) begin
        checksum_q <= csum_add(acc, data_i);
        acc        <= '0;
      end else begin
        acc <= csum_add(acc, data_i);
      end
    end
  end

  assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_systolic_row_packer.sv
// Testbench for systolic_row_packer: directed streams with a scoreboard queue of
// expected rows, popped by an independent monitor on every sink handshake.
module tb_systolic_row_packer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        yumi_o;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] data_o;
  logic [2:0]  row_o;
  logic        last_o;
  logic        frame_done_o;
  logic        busy_o;
`ifdef SYSTOLIC_ROW_PACKER_CHECKSUM_EN
  logic [15:0] checksum_o;
`endif

  systolic_row_packer #(
    .width_p(8), .array_width_p(8), .array_height_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .valid_i(valid_i), .data_i(data_i), .yumi_o(yumi_o),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .row_o(row_o), .last_o(last_o), .frame_done_o(frame_done_o),
    .busy_o(busy_o)
`ifdef SYSTOLIC_ROW_PACKER_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  r;
    logic        l;
  } row_t;

  row_t        exp_q[$];
  logic [63:0] popped_data[$];
  logic [2:0]  popped_row[$];
  logic        popped_last[$];

  int n_vec  = 0;
  int n_fail = 0;
  int fd_count = 0;
  int stalls = 0;
  logic exp_fd = 1'b0;

  // bench model of the packer
  int          m_col = 0;
  int          m_row = 0;
  logic [63:0] m_word = '0;
  logic [15:0] m_acc = '0;
  logic [15:0] m_csum = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic model_accept(input logic [7:0] v);
    row_t e;
    m_word[m_col*8 +: 8] = v;
    if (m_col == 7) begin
      e.d = m_word;
      e.r = 3'(m_row);
      e.l = (m_row == 7);
      exp_q.push_back(e);
      if (m_row == 7) begin
        m_csum = m_acc + 16'(v);
        m_acc  = '0;
      end else begin
        m_acc = m_acc + 16'(v);
      end
      m_col  = 0;
      m_row  = (m_row + 1) % 8;
      m_word = '0;
    end else begin
      m_acc = m_acc + 16'(v);
      m_col++;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_col = 0; m_row = 0; m_word = '0; m_acc = '0; m_csum = '0;
  endtask

  // Present one element and hold it until the DUT consumes it.
  task automatic send_elem(input logic [7:0] v);
    int tries;
    tries   = 0;
    valid_i = 1'b1;
    data_i  = v;
    @(negedge clk);
    while (!yumi_o && tries < 200) begin
      tries++;
      @(negedge clk);
    end
    if (!yumi_o) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: element 0x%0h not consumed within 200 cycles", v);
      valid_i = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(v);
      stalls += tries;
      #1;
    end
  endtask

  task automatic drain();
    int tries;
    tries = 0;
    while ((valid_o || exp_q.size() != 0) && tries < 300) begin
      @(negedge clk);
      tries++;
    end
    if (valid_o || exp_q.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: valid_o=%0d, %0d rows still expected", valid_o, exp_q.size());
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(posedge clk);
    model_clear();
    #1 flush_i = 1'b0;
  endtask

  // monitor: frame_done pulse check and row scoreboard
  always @(negedge clk) begin
    if (reset_i) begin
      exp_fd = 1'b0;
    end else begin
      chk("frame_done", 64'(frame_done_o), 64'(exp_fd));
      if (frame_done_o) fd_count++;
      exp_fd = valid_o & ready_i & ~flush_i & last_o;
      if (valid_o && ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_row: got row %0d data 0x%0h, expected none", row_o, data_o);
        end else begin
          row_t e;
          e = exp_q.pop_front();
          chk("row_data", data_o, e.d);
          chk("row_idx", 64'(row_o), 64'(e.r));
          chk("row_last", 64'(last_o), 64'(e.l));
        end
        popped_data.push_back(data_o);
        popped_row.push_back(row_o);
        popped_last.push_back(last_o);
      end
    end
  end

  initial begin
    int base;
    int fd_before;
    bit done;
    reset_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(valid_o), 0);
    chk("rst_data", data_o, 0);
    chk("rst_row", 64'(row_o), 0);
    chk("rst_last", 64'(last_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_yumi", 64'(yumi_o), 0);
`ifdef SYSTOLIC_ROW_PACKER_CHECKSUM_EN
    chk("rst_csum", 64'(checksum_o), 0);
`endif
    @(posedge clk); #1;

    // full frame at full rate
    ready_i = 1'b1;
    stalls  = 0;
    for (int i = 1; i <= 64; i++) send_elem(8'(i));
    valid_i = 1'b0;
    drain();
    chk("t1_stalls", 64'(stalls), 0);
    chk("t1_rows", 64'(popped_data.size()), 8);
    chk("t1_row0_data", popped_data[0], 64'h0807060504030201);
    chk("t1_row0_idx", 64'(popped_row[0]), 0);
    chk("t1_row7_last", 64'(popped_last[7]), 1);
    chk("t1_row6_last", 64'(popped_last[6]), 0);
    chk("t1_frame_done", 64'(fd_count), 1);
`ifdef SYSTOLIC_ROW_PACKER_CHECKSUM_EN
    chk("t1_checksum", 64'(checksum_o), 2080);
    chk("t1_checksum_model", 64'(checksum_o), 64'(m_csum));
`endif

    // backpressure: FIFO fills, row-completing element stalls
    ready_i = 1'b0;
    base = popped_data.size();
    for (int i = 1; i <= 23; i++) send_elem(8'(i));
    valid_i = 1'b1; data_i = 8'd24;
    repeat (3) begin
      @(negedge clk);
      chk("t2_yumi_stall", 64'(yumi_o), 0);
      chk("t2_valid", 64'(valid_o), 1);
      chk("t2_head_row", 64'(row_o), 0);
      chk("t2_head_data", data_o, 64'h0807060504030201);
    end
    @(posedge clk); #1 ready_i = 1'b1;
    send_elem(8'd24);
    valid_i = 1'b0;
    drain();
    chk("t2_rows", 64'(popped_data.size() - base), 3);
    for (int k = 0; k < 3; k++) chk("t2_row_order", 64'(popped_row[base+k]), 64'(k));

    // flush of a partial row
    for (int i = 0; i < 5; i++) send_elem(8'(8'h11 + i));
    valid_i = 1'b0;
    do_flush();
    @(negedge clk);
    chk("t3_busy", 64'(busy_o), 0);
    chk("t3_valid", 64'(valid_o), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_elem(8'(8'hA1 + i));
    valid_i = 1'b0;
    drain();
    chk("t3_row_idx", 64'(popped_row[popped_row.size()-1]), 0);
    chk("t3_row_data", popped_data[popped_data.size()-1], 64'hA8A7A6A5A4A3A2A1);

    // flush while the last row of a frame is being handed over
    for (int i = 0; i < 48; i++) send_elem(8'(i + 8'h40));
    valid_i = 1'b0;
    drain();
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send_elem(8'(i + 8'hC0));
    valid_i = 1'b0;
    @(posedge clk); #1;
    ready_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1; data_i = 8'h55;
    @(negedge clk);
    chk("t4_valid", 64'(valid_o), 1);
    chk("t4_last", 64'(last_o), 1);
    chk("t4_row", 64'(row_o), 7);
    chk("t4_yumi", 64'(yumi_o), 0);
    fd_before = fd_count;
    @(posedge clk);
    model_clear();
    #1 flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("t4_valid_after", 64'(valid_o), 0);
    chk("t4_busy_after", 64'(busy_o), 0);
    repeat (2) @(negedge clk);
    chk("t4_no_frame_done", 64'(fd_count), 64'(fd_before));
    @(posedge clk); #1;

    // asynchronous reset mid-row with a row queued
    ready_i = 1'b0;
    for (int i = 0; i < 11; i++) send_elem(8'(i + 8'h31));
    valid_i = 1'b0;
    #1 reset_i = 1'b1;
    #1;
    chk("t5_valid", 64'(valid_o), 0);
    chk("t5_busy", 64'(busy_o), 0);
    chk("t5_data", data_o, 0);
    chk("t5_row", 64'(row_o), 0);
    chk("t5_last", 64'(last_o), 0);
    chk("t5_yumi", 64'(yumi_o), 0);
    chk("t5_frame_done", 64'(frame_done_o), 0);
`ifdef SYSTOLIC_ROW_PACKER_CHECKSUM_EN
    chk("t5_csum", 64'(checksum_o), 0);
`endif
    model_clear();
    @(negedge clk);
    #2 reset_i = 1'b0;
    @(posedge clk); #1;

    // two back-to-back frames with random sink backpressure
    base = popped_data.size();
    fd_before = fd_count;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 128; i++) send_elem(8'(i * 3 + 7));
        valid_i = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    ready_i = 1'b1;
    drain();
    chk("t6_rows", 64'(popped_data.size() - base), 16);
    for (int k = 0; k < 16; k++) chk("t6_row_seq", 64'(popped_row[base+k]), 64'(k % 8));
    chk("t6_frame_done", 64'(fd_count - fd_before), 2);
`ifdef SYSTOLIC_ROW_PACKER_CHECKSUM_EN
    chk("t6_checksum", 64'(checksum_o), 64'(m_csum));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
